// File: rtl/cpu_tick_gen.sv
// CPU run-control: holds the CPU in reset, runs/pauses/single-steps it, and
// turns the speed exponent into a cpu_ce pulse train of period 2^(e+BASE_SHIFT).
module cpu_tick_gen #(
  parameter int BASE_SHIFT   = 8,
  parameter int CNT_W        = 24,
  parameter int RESET_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] delay,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd,
  output logic        cpu_ce,
  output logic        cpu_rst,
  output logic        running,
  output logic [15:0] ce_count
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  localparam logic [7:0] CMD_RESET = 8'd0;
  localparam logic [7:0] CMD_START = 8'd1;
  localparam logic [7:0] CMD_PAUSE = 8'd2;
  localparam logic [7:0] CMD_STEP  = 8'd4;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [HOLD_W-1:0]  hold_r, hold_nxt_s;
  logic               ce_nxt_s;
  logic               rst_nxt_s;
  logic               running_nxt_s;
  logic [15:0]        count_nxt_s;

  logic [3:0]         exp_s;
  logic [7:0]         shift_s;
  logic [CNT_W-1:0]   p_last_s;
  logic               do_reset_s, do_start_s, do_pause_s, do_step_s;
  logic               unused_delay_s;

  // Only the low nibble selects the speed; the upper bits are don't-care.
  assign unused_delay_s = ^delay[15:4];

  // Exponent 0 is promoted to 1; P-1 is the terminal count for the >= compare.
  assign exp_s    = (delay[3:0] == 4'd0) ? 4'd1 : delay[3:0];
  assign shift_s  = 8'(exp_s) + 8'(BASE_SHIFT);
  assign p_last_s = (CNT_W'(1) << shift_s) - CNT_W'(1);

  assign do_reset_s = cmd_valid && (cmd == CMD_RESET);
  assign do_start_s = cmd_valid && (cmd == CMD_START);
  assign do_pause_s = cmd_valid && (cmd == CMD_PAUSE);
  assign do_step_s  = cmd_valid && (cmd == CMD_STEP);

  // Next-state and next-output logic for the run-control FSM.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    hold_nxt_s  = hold_r;
    ce_nxt_s    = 1'b0;
    rst_nxt_s   = 1'b0;
    count_nxt_s = ce_count;
    case (state_r)
      ST_HOLD: begin
        rst_nxt_s = 1'b1;
        cnt_nxt_s = CNT_W'(0);
        if (do_reset_s) begin
          hold_nxt_s = HOLD_W'(0);
        end else if (hold_r == HOLD_LAST) begin
          state_nxt_s = ST_PAUSE;
          rst_nxt_s   = 1'b0;
          hold_nxt_s  = HOLD_W'(0);
        end else begin
          hold_nxt_s = hold_r + HOLD_W'(1);
        end
      end
      ST_PAUSE: begin
        cnt_nxt_s = CNT_W'(0);
        if (do_reset_s) begin
          state_nxt_s = ST_HOLD;
          hold_nxt_s  = HOLD_W'(0);
          count_nxt_s = 16'd0;
          rst_nxt_s   = 1'b1;
        end else if (do_start_s) begin
          state_nxt_s = ST_RUN;
        end else if (do_step_s) begin
          ce_nxt_s    = 1'b1;
          count_nxt_s = ce_count + 16'd1;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_RUN: begin
        if (do_reset_s) begin
          state_nxt_s = ST_HOLD;
          hold_nxt_s  = HOLD_W'(0);
          cnt_nxt_s   = CNT_W'(0);
          count_nxt_s = 16'd0;
          rst_nxt_s   = 1'b1;
        end else if (do_pause_s) begin
          // A pulse that would have fired on this edge is dropped.
          state_nxt_s = ST_PAUSE;
          cnt_nxt_s   = CNT_W'(0);
        end else if (cnt_r >= p_last_s) begin
          ce_nxt_s    = 1'b1;
          cnt_nxt_s   = CNT_W'(0);
          count_nxt_s = ce_count + 16'd1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_HOLD;
        hold_nxt_s  = HOLD_W'(0);
        cnt_nxt_s   = CNT_W'(0);
        count_nxt_s = 16'd0;
        rst_nxt_s   = 1'b1;
      end
    endcase
    running_nxt_s = (state_nxt_s == ST_RUN);
  end

  // State and registered outputs; port reset wins over any command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_HOLD;
      cnt_r    <= CNT_W'(0);
      hold_r   <= HOLD_W'(0);
      cpu_ce   <= 1'b0;
      cpu_rst  <= 1'b1;
      running  <= 1'b0;
      ce_count <= 16'd0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      hold_r   <= hold_nxt_s;
      cpu_ce   <= ce_nxt_s;
      cpu_rst  <= rst_nxt_s;
      running  <= running_nxt_s;
      ce_count <= count_nxt_s;
    end
  end

endmodule

// File: tb/tb_cpu_tick_gen.sv
// Bench for cpu_tick_gen: a vector table, directed multi-cycle sequences,
// and random commands/delays checked every cycle against a behavioural model.
module tb_cpu_tick_gen;

  localparam int BS = 2;
  localparam int RC = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] delay = 16'd1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd = 8'hFF;
  logic        cpu_ce, cpu_rst, running;
  logic [15:0] ce_count;

  cpu_tick_gen #(.BASE_SHIFT(BS), .CNT_W(24), .RESET_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .delay(delay), .cmd_valid(cmd_valid), .cmd(cmd),
    .cpu_ce(cpu_ce), .cpu_rst(cpu_rst), .running(running), .ce_count(ce_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: mode, remaining hold cycles, cycles elapsed in the period.
  localparam int M_HOLD = 0, M_PAUSE = 1, M_RUN = 2;
  int          m_mode = M_HOLD;
  int          m_hold_left = RC - 1;
  int          m_elapsed = 0;
  logic        m_ce = 1'b0;
  logic        m_rst = 1'b1;
  logic [15:0] m_count = 16'd0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_enter_hold();
    m_mode = M_HOLD; m_hold_left = RC - 1; m_elapsed = 0;
    m_count = 16'd0; m_ce = 1'b0; m_rst = 1'b1;
  endtask

  task automatic model_step();
    int e;
    int period;
    e = int'(delay[3:0]);
    if (e == 0) e = 1;
    period = 1 << (e + BS);
    if (reset) begin
      model_enter_hold();
    end else if (m_mode == M_HOLD) begin
      m_ce = 1'b0;
      if (cmd_valid && cmd == 8'd0) m_hold_left = RC - 1;
      else if (m_hold_left == 0) begin m_mode = M_PAUSE; m_rst = 1'b0; end
      else m_hold_left--;
    end else if (m_mode == M_PAUSE) begin
      m_ce = 1'b0;
      if (cmd_valid && cmd == 8'd0) model_enter_hold();
      else if (cmd_valid && cmd == 8'd1) begin m_mode = M_RUN; m_elapsed = 0; end
      else if (cmd_valid && cmd == 8'd4) begin m_ce = 1'b1; m_count++; end
    end else begin
      if (cmd_valid && cmd == 8'd0) model_enter_hold();
      else if (cmd_valid && cmd == 8'd2) begin m_mode = M_PAUSE; m_elapsed = 0; m_ce = 1'b0; end
      else begin
        m_elapsed++;
        if (m_elapsed >= period) begin m_ce = 1'b1; m_count++; m_elapsed = 0; end
        else m_ce = 1'b0;
      end
    end
  endtask

  // One clock: model follows the same sampled inputs, outputs compared 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_ce", 32'(cpu_ce), 32'(m_ce));
    check("model_rst", 32'(cpu_rst), 32'(m_rst));
    check("model_running", 32'(running), 32'(m_mode == M_RUN));
    check("model_count", 32'(ce_count), 32'(m_count));
  endtask

  task automatic cmd_once(logic [7:0] c);
    cmd_valid = 1'b1; cmd = c;
    tick();
    cmd_valid = 1'b0; cmd = 8'hFF;
  endtask

  task automatic measure(logic [15:0] d, output int p);
    p = -1;
    delay = d;
    cmd_once(8'd1);
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (cpu_ce) begin p = k; break; end
    end
    cmd_once(8'd2);
  endtask

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  c;
    logic [15:0] d;
    logic        e_ce;
    logic        e_rst;
    logic        e_run;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[13];

  initial begin
    int pulses, rcyc, pa, pb;

    vt[0] = '{1'b1, 1'b0, 8'hFF, 16'd1, 1'b0, 1'b1, 1'b0, 16'd0};
    for (int i = 1; i <= 7; i++) vt[i] = '{1'b0, 1'b0, 8'hFF, 16'd1, 1'b0, 1'b1, 1'b0, 16'd0};
    vt[8]  = '{1'b0, 1'b0, 8'hFF, 16'd1, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[9]  = '{1'b0, 1'b1, 8'd4,  16'd1, 1'b1, 1'b0, 1'b0, 16'd1};
    vt[10] = '{1'b0, 1'b0, 8'hFF, 16'd1, 1'b0, 1'b0, 1'b0, 16'd1};
    vt[11] = '{1'b0, 1'b1, 8'd0,  16'd1, 1'b0, 1'b1, 1'b0, 16'd0};
    vt[12] = '{1'b0, 1'b1, 8'd1,  16'd1, 1'b0, 1'b1, 1'b0, 16'd0};

    for (int i = 0; i < 13; i++) begin
      reset = vt[i].rst; cmd_valid = vt[i].v; cmd = vt[i].c; delay = vt[i].d;
      tick();
      check($sformatf("vec%0d_ce", i), 32'(cpu_ce), 32'(vt[i].e_ce));
      check($sformatf("vec%0d_rst", i), 32'(cpu_rst), 32'(vt[i].e_rst));
      check($sformatf("vec%0d_run", i), 32'(running), 32'(vt[i].e_run));
      check($sformatf("vec%0d_cnt", i), 32'(ce_count), 32'(vt[i].e_cnt));
    end
    cmd_valid = 1'b0; cmd = 8'hFF;

    // Reset for one cycle: cpu_rst high for RC cycles, then silence in PAUSE.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rcyc = int'(cpu_rst);
    for (int k = 0; k < 20; k++) begin tick(); rcyc += int'(cpu_rst); end
    check("t1_rst_cycles", 32'(rcyc), 32'(RC));
    pulses = 0;
    for (int k = 0; k < 1000; k++) begin tick(); pulses += int'(cpu_ce); end
    check("t1_no_ce", 32'(pulses), 32'd0);
    check("t1_running", 32'(running), 32'd0);

    // Three single steps, five cycles apart.
    pulses = 0;
    for (int s = 0; s < 3; s++) begin
      cmd_once(8'd4);
      check("t3_step_pulse", 32'(cpu_ce), 32'd1);
      pulses += int'(cpu_ce);
      for (int k = 0; k < 4; k++) begin tick(); pulses += int'(cpu_ce); end
    end
    check("t3_pulses", 32'(pulses), 32'd3);
    check("t3_count", 32'(ce_count), 32'd3);

    // delay=1 with BASE_SHIFT=2: period 8 from the START edge.
    delay = 16'd1;
    cmd_once(8'd1);
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (cpu_ce) begin
        pulses++;
        check("t2_phase", 32'(k % 8), 32'd0);
      end
    end
    check("t2_pulses", 32'(pulses), 32'd5);
    check("t2_running", 32'(running), 32'd1);
    check("t2_count", 32'(ce_count), 32'd8);
    cmd_once(8'd2);

    // P=64, shrink to P=16 at cnt=40: fires next edge, then every 16.
    delay = 16'd4;
    cmd_once(8'd1);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin tick(); pulses += int'(cpu_ce); end
    check("t4_early", 32'(pulses), 32'd0);
    delay = 16'd2;
    tick();
    check("t4_shrink", 32'(cpu_ce), 32'd1);
    for (int k = 1; k <= 32; k++) begin
      tick();
      check("t4_period16", 32'(cpu_ce), 32'(k % 16 == 0));
    end
    cmd_once(8'd2);

    // Exponent 0 behaves as 1; upper delay bits are ignored.
    measure(16'd0, pa);
    measure(16'd1, pb);
    check("t5_d0_vs_d1", 32'(pa), 32'(pb));
    check("t5_d0", 32'(pa), 32'd8);
    measure(16'h0013, pa);
    measure(16'd3, pb);
    check("t5_d13_vs_d3", 32'(pa), 32'(pb));
    check("t5_d13", 32'(pa), 32'd32);

    // RESET_CPU mid-run, START during the hold is ignored.
    delay = 16'd1;
    cmd_once(8'd1);
    for (int k = 0; k < 20; k++) tick();
    cmd_once(8'd0);
    check("t6_ce", 32'(cpu_ce), 32'd0);
    check("t6_count", 32'(ce_count), 32'd0);
    check("t6_rst", 32'(cpu_rst), 32'd1);
    rcyc = int'(cpu_rst);
    cmd_once(8'd1);
    rcyc += int'(cpu_rst);
    for (int k = 0; k < 15; k++) begin tick(); rcyc += int'(cpu_rst); end
    check("t6_rst_cycles", 32'(rcyc), 32'(RC));
    check("t6_paused", 32'(running), 32'd0);

    // Random commands and delays against the model.
    for (int k = 0; k < 3000; k++) begin
      int r;
      reset = ($urandom_range(0, 599) == 0);
      cmd_valid = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 19);
      if (r == 0) cmd = 8'd0;
      else if (r <= 6) cmd = 8'd1;
      else if (r <= 11) cmd = 8'd2;
      else if (r <= 16) cmd = 8'd4;
      else cmd = 8'(8'h03 + 8'($urandom_range(0, 1)) * 8'h52);
      if ($urandom_range(0, 49) == 0) delay = 16'($urandom) & 16'hFFF3;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
